mem_system: RTL

- Memory and I/O subsystem sitting directly downstream of the 8-bit CPU's memory port. It serves every fetch, load and store.
- Provides a RAM region with combinational read and synchronous write, plus a memory-mapped I/O page:
  - transmit FIFO with valid/ready output,
  - single-byte receive holding register,
  - free-running cycle timer,
  - status/overflow register.
- A separate load port lets the test harness or boot logic preload the program image.

---
 rtl/mem_system.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_system.sv
// CPU-facing memory subsystem: RAM below IO_BASE plus a memory-mapped I/O page
// (TX FIFO, RX holding register, cycle timer, status/overflow).
module mem_system #(
  parameter logic [7:0]  IO_BASE  = 8'hF0,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_wen,
  input  logic [7:0] mem_address,
  input  logic [7:0] mem_data_in,
  output logic [7:0] mem_data_out,
  input  logic       load_wen,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned RAM_WORDS = 32'(IO_BASE);
  localparam int unsigned PTR_W     = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [7:0] TXD_ADDR   = IO_BASE;
  localparam logic [7:0] STAT_ADDR  = IO_BASE + 8'd1;
  localparam logic [7:0] RXD_ADDR   = IO_BASE + 8'd2;
  localparam logic [7:0] RXACK_ADDR = IO_BASE + 8'd3;
  localparam logic [7:0] TMR_ADDR   = IO_BASE + 8'd4;

  logic [7:0]       ram    [RAM_WORDS];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             ovf;
  logic             rx_full;
  logic [7:0]       rx_hold;
  logic [7:0]       timer;

  logic cpu_in_ram;
  logic load_ok;
  logic io_wen;
  logic wr_txd;
  logic wr_stat;
  logic wr_rxack;
  logic wr_tmr;
  logic tx_full;
  logic tx_empty;
  logic tx_pop;
  logic tx_push;
  logic ovf_set;
  logic rx_capture;

  assign cpu_in_ram = mem_address < IO_BASE;
  assign load_ok    = load_wen && (load_addr < IO_BASE);

  // I/O register writes are suppressed while rst is high; RAM writes are not.
  assign io_wen     = mem_wen && !rst;
  assign wr_txd     = io_wen && (mem_address == TXD_ADDR);
  assign wr_stat    = io_wen && (mem_address == STAT_ADDR);
  assign wr_rxack   = io_wen && (mem_address == RXACK_ADDR);
  assign wr_tmr     = io_wen && (mem_address == TMR_ADDR);

  assign tx_full    = tx_count == CNT_W'(TX_DEPTH);
  assign tx_empty   = tx_count == '0;
  assign tx_pop     = !tx_empty && tx_ready;
  assign tx_push    = wr_txd && (!tx_full || tx_pop);
  assign ovf_set    = wr_txd && tx_full && !tx_pop;
  assign rx_capture = rx_valid && !rx_full;

  assign tx_valid   = !tx_empty;
  assign tx_data    = tx_empty ? 8'h00 : tx_mem[rd_ptr];
  assign rx_ready   = !rx_full;

  // RAM is never reset; the preload port takes priority over CPU stores.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      ram[load_addr] <= load_data;
    end else if (mem_wen && cpu_in_ram) begin
      ram[mem_address] <= mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[wr_ptr] <= mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Overflow is sticky; a same-cycle overflow beats a STAT clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (wr_stat) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end else if (wr_rxack) begin
      rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= 8'h00;
    end else if (wr_tmr) begin
      timer <= mem_data_in;
    end else begin
      timer <= timer + 8'd1;
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    mem_data_out = 8'h00;
    if (cpu_in_ram) begin
      mem_data_out = ram[mem_address];
    end else begin
      case (mem_address)
        STAT_ADDR: mem_data_out = {4'b0000, ovf, rx_full, tx_empty, tx_full};
        RXD_ADDR:  mem_data_out = rx_full ? rx_hold : 8'h00;
        TMR_ADDR:  mem_data_out = timer;
        default:   mem_data_out = 8'h00;
      endcase
    end
  end

endmodule
